emu_host_sequencer: RTL and testbench

- Sits between the host wire-in/wire-out endpoints and the emulator top's three decoupled channels: instructions, io input and io output.
- Converts host toggle-based transfers into single-beat valid/ready handshakes on the emulator side, so a level held on a wire-in can never cause a repeated transfer.
- Sequences the emulator through a load phase and a run phase. The load phase accepts exactly host_steps*used_procs instructions; the run phase opens the io channels.
- Reports phase, instruction count and sticky protocol errors back to the host.

---
 rtl/emu_host_sequencer.sv | 297 +++++++++++++++++++++++++++++
 tb/tb_emu_host_sequencer.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/emu_host_sequencer.sv
// emu_host_sequencer
// Bridges host wire-in/wire-out toggle transfers onto the emulator's three
// valid/ready channels (instructions, io input, io output) and sequences the
// emulator through IDLE -> LOAD -> RUN, with DRAIN used to finish any
// outstanding beat before a restart.
// Optional macro HOST_CDC_SYNC_EN: start, host_insn_tog, host_in_tog and
// host_out_ack pass through 2-flop synchronisers before use.
module emu_host_sequencer #(
    parameter int unsigned WORD_W     = 16,
    parameter int unsigned INSN_WORDS = 3,
    parameter int unsigned STEP_W     = 16,
    parameter int unsigned PROC_W     = 4,
    parameter int unsigned CNT_W      = STEP_W + PROC_W
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [STEP_W-1:0]            cfg_host_steps,
    input  logic [PROC_W-1:0]            cfg_used_procs,
    input  logic                         start,
    input  logic [WORD_W*INSN_WORDS-1:0] host_insn_bits,
    input  logic                         host_insn_tog,
    output logic                         host_insn_ack,
    input  logic [WORD_W-1:0]            host_in_bits,
    input  logic                         host_in_tog,
    output logic                         host_in_ack,
    output logic [WORD_W-1:0]            host_out_bits,
    output logic                         host_out_tog,
    input  logic                         host_out_ack,
    output logic                         emu_insns_valid,
    input  logic                         emu_insns_ready,
    output logic [WORD_W*INSN_WORDS-1:0] emu_insns_bits,
    output logic                         emu_in_valid,
    input  logic                         emu_in_ready,
    output logic [WORD_W-1:0]            emu_in_bits,
    input  logic                         emu_out_valid,
    output logic                         emu_out_ready,
    input  logic [WORD_W-1:0]            emu_out_bits,
    output logic [1:0]                   phase,
    output logic [CNT_W-1:0]             insn_count,
    output logic [2:0]                   err
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_RUN   = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    state_t                         r_state;
    state_t                         w_state_nxt;

    // host control levels as seen in the clock domain
    logic                           w_start_s;
    logic                           w_insn_tog_s;
    logic                           w_in_tog_s;
    logic                           w_out_ack_s;

    logic                           r_start_q;
    logic                           w_start_edge;

    logic [CNT_W-1:0]               w_total;
    logic [CNT_W-1:0]               w_total_cur;
    logic [CNT_W-1:0]               r_total;
    logic [CNT_W-1:0]               r_insn_count;
    logic [CNT_W-1:0]               w_count_inc;
    logic                           w_count_clr;
    logic                           w_err0_set;

    logic                           r_insn_valid;
    logic [WORD_W*INSN_WORDS-1:0]   r_insn_bits;
    logic                           r_insn_ack;
    logic                           w_insn_pend;
    logic                           w_insn_capture;
    logic                           w_insn_fire;

    logic                           r_in_valid;
    logic [WORD_W-1:0]              r_in_bits;
    logic                           r_in_ack;
    logic                           w_in_pend;
    logic                           w_in_capture;
    logic                           w_in_fire;

    logic [WORD_W-1:0]              r_out_bits;
    logic                           r_out_tog;
    logic                           w_out_ready;
    logic                           w_out_fire;

    logic                           w_drained;
    logic [2:0]                     r_err;

`ifdef HOST_CDC_SYNC_EN
    logic [3:0]                     r_sync1;
    logic [3:0]                     r_sync2;

    // two-flop synchronisers for the host control levels (payloads are not
    // synchronised: the host holds them stable before it toggles)
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= {host_out_ack, host_in_tog, host_insn_tog, start};
            r_sync2 <= r_sync1;
        end
    end

    assign w_start_s    = r_sync2[0];
    assign w_insn_tog_s = r_sync2[1];
    assign w_in_tog_s   = r_sync2[2];
    assign w_out_ack_s  = r_sync2[3];
`else
    assign w_start_s    = start;
    assign w_insn_tog_s = host_insn_tog;
    assign w_in_tog_s   = host_in_tog;
    assign w_out_ack_s  = host_out_ack;
`endif

    // previous start level for rising-edge detection
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_start_q <= 1'b0;
        end else begin
            r_start_q <= w_start_s;
        end
    end

    assign w_start_edge = w_start_s & ~r_start_q;

    // full-width product so large step*proc counts never wrap
    assign w_total     = CNT_W'(cfg_host_steps) * CNT_W'(cfg_used_procs);
    // a start edge in the same cycle as the end of a drain uses the new total
    assign w_total_cur = w_start_edge ? w_total : r_total;

    // program length, re-latched on every start edge
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_total <= '0;
        end else if (w_start_edge) begin
            r_total <= w_total;
        end
    end

    // a pending transfer is a host toggle not yet answered by our ack
    assign w_insn_pend    = w_insn_tog_s ^ r_insn_ack;
    assign w_in_pend      = w_in_tog_s ^ r_in_ack;

    assign w_insn_capture = (r_state == S_LOAD) & w_insn_pend & ~r_insn_valid;
    assign w_in_capture   = (r_state == S_RUN) & w_in_pend & ~r_in_valid;
    assign w_insn_fire    = r_insn_valid & emu_insns_ready;
    assign w_in_fire      = r_in_valid & emu_in_ready;

    // holding register is empty when our tog matches the host's ack
    assign w_out_ready    = (r_state == S_RUN) & (r_out_tog == w_out_ack_s);
    assign w_out_fire     = emu_out_valid & w_out_ready;

    assign w_count_inc    = r_insn_count + CNT_W'(1);
    // a beat completing this edge counts as already drained
    assign w_drained      = (~r_insn_valid | w_insn_fire) & (~r_in_valid | w_in_fire);

    // phase register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // next phase, counter clear and zero-length error decision
    always_comb begin
        w_state_nxt = r_state;
        w_count_clr = 1'b0;
        w_err0_set  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_start_edge) begin
                    if (w_total == '0) begin
                        w_err0_set = 1'b1;
                    end else begin
                        w_state_nxt = S_LOAD;
                        w_count_clr = 1'b1;
                    end
                end
            end
            S_LOAD: begin
                if (w_start_edge) begin
                    w_state_nxt = S_DRAIN;
                end else if (w_insn_fire && (w_count_inc == r_total)) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (w_start_edge) begin
                    w_state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (w_drained) begin
                    if (w_total_cur == '0) begin
                        w_state_nxt = S_IDLE;
                        w_err0_set  = 1'b1;
                    end else begin
                        w_state_nxt = S_LOAD;
                        w_count_clr = 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // instructions accepted during the current load
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_insn_count <= '0;
        end else if (w_count_clr) begin
            r_insn_count <= '0;
        end else if (w_insn_fire) begin
            r_insn_count <= w_count_inc;
        end
    end

    // instruction channel: single beat per host toggle, held until ready
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_insn_valid <= 1'b0;
            r_insn_bits  <= '0;
            r_insn_ack   <= 1'b0;
        end else if (w_insn_fire) begin
            r_insn_valid <= 1'b0;
            r_insn_ack   <= ~r_insn_ack;
        end else if (w_insn_capture) begin
            r_insn_valid <= 1'b1;
            r_insn_bits  <= host_insn_bits;
        end
    end

    // io input channel: same single-beat rule, open only in RUN
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_in_valid <= 1'b0;
            r_in_bits  <= '0;
            r_in_ack   <= 1'b0;
        end else if (w_in_fire) begin
            r_in_valid <= 1'b0;
            r_in_ack   <= ~r_in_ack;
        end else if (w_in_capture) begin
            r_in_valid <= 1'b1;
            r_in_bits  <= host_in_bits;
        end
    end

    // io output holding register: filled only when the host has read it
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_out_bits <= '0;
            r_out_tog  <= 1'b0;
        end else if (w_out_fire) begin
            r_out_bits <= emu_out_bits;
            r_out_tog  <= ~r_out_tog;
        end
    end

    // sticky protocol errors; a toggle already being served is not an error
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_err <= '0;
        end else begin
            if (w_err0_set) begin
                r_err[0] <= 1'b1;
            end
            if (w_insn_pend && !r_insn_valid && (r_state != S_LOAD)) begin
                r_err[1] <= 1'b1;
            end
            if (w_in_pend && !r_in_valid && (r_state != S_RUN)) begin
                r_err[2] <= 1'b1;
            end
        end
    end

    assign host_insn_ack   = r_insn_ack;
    assign host_in_ack     = r_in_ack;
    assign host_out_bits   = r_out_bits;
    assign host_out_tog    = r_out_tog;
    assign emu_insns_valid = r_insn_valid;
    assign emu_insns_bits  = r_insn_bits;
    assign emu_in_valid    = r_in_valid;
    assign emu_in_bits     = r_in_bits;
    assign emu_out_ready   = w_out_ready;
    assign phase           = r_state;
    assign insn_count      = r_insn_count;
    assign err             = r_err;

endmodule

// File: tb/tb_emu_host_sequencer.sv
// Self-checking bench for emu_host_sequencer: a cycle table for the load
// sequence plus hand-written sequences for stalls, io, restart and reset.
module tb_emu_host_sequencer;

`ifdef HOST_CDC_SYNC_EN
    localparam int SYNC_LAT = 2;
`else
    localparam int SYNC_LAT = 0;
`endif

    logic        clock = 1'b0;
    logic        reset;
    logic [15:0] cfg_host_steps;
    logic [3:0]  cfg_used_procs;
    logic        start;
    logic [47:0] host_insn_bits;
    logic        host_insn_tog;
    logic        host_insn_ack;
    logic [15:0] host_in_bits;
    logic        host_in_tog;
    logic        host_in_ack;
    logic [15:0] host_out_bits;
    logic        host_out_tog;
    logic        host_out_ack;
    logic        emu_insns_valid;
    logic        emu_insns_ready;
    logic [47:0] emu_insns_bits;
    logic        emu_in_valid;
    logic        emu_in_ready;
    logic [15:0] emu_in_bits;
    logic        emu_out_valid;
    logic        emu_out_ready;
    logic [15:0] emu_out_bits;
    logic [1:0]  phase;
    logic [19:0] insn_count;
    logic [2:0]  err;

    int checks = 0;
    int errors = 0;

    emu_host_sequencer #(
        .WORD_W    (16),
        .INSN_WORDS(3),
        .STEP_W    (16),
        .PROC_W    (4)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .cfg_host_steps (cfg_host_steps),
        .cfg_used_procs (cfg_used_procs),
        .start          (start),
        .host_insn_bits (host_insn_bits),
        .host_insn_tog  (host_insn_tog),
        .host_insn_ack  (host_insn_ack),
        .host_in_bits   (host_in_bits),
        .host_in_tog    (host_in_tog),
        .host_in_ack    (host_in_ack),
        .host_out_bits  (host_out_bits),
        .host_out_tog   (host_out_tog),
        .host_out_ack   (host_out_ack),
        .emu_insns_valid(emu_insns_valid),
        .emu_insns_ready(emu_insns_ready),
        .emu_insns_bits (emu_insns_bits),
        .emu_in_valid   (emu_in_valid),
        .emu_in_ready   (emu_in_ready),
        .emu_in_bits    (emu_in_bits),
        .emu_out_valid  (emu_out_valid),
        .emu_out_ready  (emu_out_ready),
        .emu_out_bits   (emu_out_bits),
        .phase          (phase),
        .insn_count     (insn_count),
        .err            (err)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        start;
        logic        tog;
        logic        ready;
        logic [47:0] bits;
        logic [1:0]  e_phase;
        logic        e_valid;
        logic        e_ack;
        logic [19:0] e_count;
        logic        chk_bits;
        logic [47:0] e_bits;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic st, logic tg, logic rd, logic [47:0] b,
                                logic [1:0] ph, logic va, logic ak,
                                logic [19:0] cn, logic cb, logic [47:0] eb);
        vec_t v;
        v.start = st;  v.tog = tg;  v.ready = rd;  v.bits = b;
        v.e_phase = ph; v.e_valid = va; v.e_ack = ak; v.e_count = cn;
        v.chk_bits = cb; v.e_bits = eb;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // advance one clock and settle just after the edge
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset           = 1'b0;
        cfg_host_steps  = '0;
        cfg_used_procs  = '0;
        start           = 1'b0;
        host_insn_bits  = '0;
        host_insn_tog   = 1'b0;
        host_in_bits    = '0;
        host_in_tog     = 1'b0;
        host_out_ack    = 1'b0;
        emu_insns_ready = 1'b0;
        emu_in_ready    = 1'b0;
        emu_out_valid   = 1'b0;
        emu_out_bits    = '0;
        step();
        step();
        reset = 1'b1;
        step();
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_phase"},     phase, 0);
        chk({tag, "_count"},     insn_count, 0);
        chk({tag, "_err"},       err, 0);
        chk({tag, "_ivalid"},    emu_insns_valid, 0);
        chk({tag, "_inval"},     emu_in_valid, 0);
        chk({tag, "_iack"},      host_insn_ack, 0);
        chk({tag, "_inack"},     host_in_ack, 0);
        chk({tag, "_outtog"},    host_out_tog, 0);
        chk({tag, "_outbits"},   host_out_bits, 0);
        chk({tag, "_outready"},  emu_out_ready, 0);
    endtask

    initial begin
        logic [47:0] p;
        logic        tg;

        // load sequence table: total = 4*2 = 8 beats, ready held high
        for (int i = 0; i < SYNC_LAT; i++)
            vecs.push_back(mk(1'b1, 1'b0, 1'b1, '0, 2'd0, 1'b0, 1'b0, 20'd0, 1'b0, '0));
        vecs.push_back(mk(1'b1, 1'b0, 1'b1, '0, 2'd1, 1'b0, 1'b0, 20'd0, 1'b0, '0));
        for (int k = 0; k < 8; k++) begin
            p  = 48'(k + 1) * 48'h0001_0001_0001;
            tg = (k % 2 == 0);
            for (int i = 0; i < SYNC_LAT; i++)
                vecs.push_back(mk(1'b0, tg, 1'b1, p, 2'd1, 1'b0, 1'(k % 2), 20'(k), 1'b0, '0));
            vecs.push_back(mk(1'b0, tg, 1'b1, p, 2'd1, 1'b1, 1'(k % 2), 20'(k), 1'b1, p));
            vecs.push_back(mk(1'b0, tg, 1'b1, p, (k == 7) ? 2'd2 : 2'd1, 1'b0,
                              1'((k + 1) % 2), 20'(k + 1), 1'b0, '0));
        end

        // reset state
        do_reset();
        chk_all_zero("rst");

        // table-driven load of 8 instructions
        cfg_host_steps = 16'd4;
        cfg_used_procs = 4'd2;
        foreach (vecs[i]) begin
            start           = vecs[i].start;
            host_insn_tog   = vecs[i].tog;
            emu_insns_ready = vecs[i].ready;
            host_insn_bits  = vecs[i].bits;
            step();
            chk($sformatf("v%0d_phase", i), phase, vecs[i].e_phase);
            chk($sformatf("v%0d_valid", i), emu_insns_valid, vecs[i].e_valid);
            chk($sformatf("v%0d_ack", i),   host_insn_ack, vecs[i].e_ack);
            chk($sformatf("v%0d_count", i), insn_count, vecs[i].e_count);
            if (vecs[i].chk_bits)
                chk($sformatf("v%0d_bits", i), emu_insns_bits, vecs[i].e_bits);
        end
        chk("load_err", err, 0);

        // stall: ready low for 5 cycles with a beat outstanding, total = 1
        do_reset();
        cfg_host_steps = 16'd1;
        cfg_used_procs = 4'd1;
        start = 1'b1;
        repeat (SYNC_LAT + 1) step();
        chk("stall_phase_load", phase, 1);
        host_insn_bits = 48'h1234_5678_9ABC;
        host_insn_tog  = 1'b1;
        repeat (SYNC_LAT + 1) step();
        host_insn_bits = 48'hFFFF_0000_FFFF;
        for (int c = 0; c < 5; c++) begin
            chk($sformatf("stall%0d_valid", c), emu_insns_valid, 1);
            chk($sformatf("stall%0d_bits", c), emu_insns_bits, 48'h1234_5678_9ABC);
            chk($sformatf("stall%0d_ack", c), host_insn_ack, 0);
            step();
        end
        emu_insns_ready = 1'b1;
        step();
        chk("stall_hs_valid", emu_insns_valid, 0);
        chk("stall_hs_ack", host_insn_ack, 1);
        chk("stall_hs_count", insn_count, 1);
        chk("stall_hs_phase", phase, 2);
        emu_insns_ready = 1'b0;

        // io input channel in RUN
        host_in_bits = 16'h1234;
        host_in_tog  = 1'b1;
        repeat (SYNC_LAT + 1) step();
        chk("in_valid", emu_in_valid, 1);
        chk("in_bits", emu_in_bits, 16'h1234);
        chk("in_ack_pre", host_in_ack, 0);
        emu_in_ready = 1'b1;
        step();
        chk("in_valid_post", emu_in_valid, 0);
        chk("in_ack_post", host_in_ack, 1);
        emu_in_ready = 1'b0;

        // io output channel: second word must wait for the host ack
        emu_out_bits  = 16'hA5A5;
        emu_out_valid = 1'b1;
        #1;
        chk("out_ready_empty", emu_out_ready, 1);
        step();
        chk("out_w1_bits", host_out_bits, 16'hA5A5);
        chk("out_w1_tog", host_out_tog, 1);
        emu_out_bits = 16'h5A5A;
        for (int c = 0; c < 3; c++) begin
            step();
            chk($sformatf("out_hold%0d_bits", c), host_out_bits, 16'hA5A5);
            chk($sformatf("out_hold%0d_rdy", c), emu_out_ready, 0);
            chk($sformatf("out_hold%0d_tog", c), host_out_tog, 1);
        end
        host_out_ack = 1'b1;
        repeat (SYNC_LAT) step();
        #1;
        chk("out_ready_after_ack", emu_out_ready, 1);
        step();
        chk("out_w2_bits", host_out_bits, 16'h5A5A);
        chk("out_w2_tog", host_out_tog, 0);
        emu_out_valid = 1'b0;
        chk("run_err", err, 0);

        // async reset mid-RUN, asserted between clock edges
        host_in_bits = 16'h0BAD;
        host_in_tog  = 1'b0;
        host_out_ack = 1'b0;
        repeat (SYNC_LAT + 1) step();
        chk("prerst_in_valid", emu_in_valid, 1);
        emu_out_bits  = 16'h0F0F;
        emu_out_valid = 1'b1;
        step();
        emu_out_valid = 1'b0;
        chk("prerst_outtog", host_out_tog, 1);
        chk("prerst_phase", phase, 2);
        #3;
        reset = 1'b0;
        #1;
        chk_all_zero("arst");

        // zero-length program and toggles outside their phase
        do_reset();
        cfg_host_steps = 16'd0;
        cfg_used_procs = 4'd5;
        start = 1'b1;
        repeat (SYNC_LAT + 1) step();
        chk("zero_phase", phase, 0);
        chk("zero_err", err, 3'b001);
        host_insn_tog = 1'b1;
        repeat (SYNC_LAT + 1) step();
        chk("idle_insn_err", err, 3'b011);
        chk("idle_insn_ack", host_insn_ack, 0);
        chk("idle_insn_valid", emu_insns_valid, 0);
        host_in_tog = 1'b1;
        repeat (SYNC_LAT + 1) step();
        chk("idle_in_err", err, 3'b111);
        chk("idle_in_ack", host_in_ack, 0);

        // restart mid-LOAD with a beat outstanding
        do_reset();
        cfg_host_steps = 16'd4;
        cfg_used_procs = 4'd1;
        start = 1'b1;
        repeat (SYNC_LAT + 1) step();
        chk("rs_phase_load", phase, 1);
        start          = 1'b0;
        host_insn_bits = 48'hDEAD_BEEF_0001;
        host_insn_tog  = 1'b1;
        repeat (SYNC_LAT + 1) step();
        chk("rs_valid", emu_insns_valid, 1);
        cfg_host_steps = 16'd2;
        start = 1'b1;
        repeat (SYNC_LAT + 1) step();
        for (int c = 0; c < 3; c++) begin
            chk($sformatf("rs_drain%0d_phase", c), phase, 3);
            chk($sformatf("rs_drain%0d_valid", c), emu_insns_valid, 1);
            chk($sformatf("rs_drain%0d_ack", c), host_insn_ack, 0);
            chk($sformatf("rs_drain%0d_ordy", c), emu_out_ready, 0);
            step();
        end
        emu_insns_ready = 1'b1;
        step();
        chk("rs_reload_phase", phase, 1);
        chk("rs_reload_count", insn_count, 0);
        chk("rs_reload_valid", emu_insns_valid, 0);
        chk("rs_reload_ack", host_insn_ack, 1);
        // new total is 2*1: two more beats complete the load
        host_insn_tog = 1'b0;
        repeat (SYNC_LAT + 1) step();
        chk("rs_b1_valid", emu_insns_valid, 1);
        step();
        chk("rs_b1_count", insn_count, 1);
        chk("rs_b1_phase", phase, 1);
        host_insn_tog = 1'b1;
        repeat (SYNC_LAT + 1) step();
        chk("rs_b2_valid", emu_insns_valid, 1);
        step();
        chk("rs_b2_count", insn_count, 2);
        chk("rs_b2_phase", phase, 2);
        chk("rs_err", err, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // absolute time bound so the run always ends
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, checks %0d", checks);
        $fatal(1);
    end

endmodule
